// File: rtl/dsp_seq_pkg.sv
// Purpose : shared types and pipeline constants for the dsp_slice MAC sequencer.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
package dsp_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_DRAIN,
    ST_HOLD
  } seq_state_t;

  // Mode tag carried alongside each issued operand slot.
  typedef enum logic [1:0] {
    TAG_NONE,
    TAG_MUL,
    TAG_ACC
  } slot_tag_t;

  // Slot -> mode bits at the slice, and slot -> result capture.
  localparam int CTRL_DELAY    = 2;
  localparam int CAPTURE_DELAY = 3;

endpackage

// File: rtl/dsp_seq_ctrl_pipe.sv
// Purpose : delay line aligning slot tags and the "last" flag with the slice pipeline.
// Latency : tag out TAG_DEPTH cycles after slot, last out LAST_DEPTH cycles after slot.
// Backpressure: none; shifts every cycle (the slice has no hold mode).
// Ports   : clk, rst_n (async active-low clear), i_tag/i_last (slot in),
//           o_tag/o_last (delayed). Both depths must be >= 2.
module dsp_seq_ctrl_pipe
  import dsp_seq_pkg::*;
#(
  parameter int TAG_DEPTH  = CTRL_DELAY,
  parameter int LAST_DEPTH = CAPTURE_DELAY
) (
  input  logic      clk,
  input  logic      rst_n,
  input  slot_tag_t i_tag,
  input  logic      i_last,
  output slot_tag_t o_tag,
  output logic      o_last
);

  slot_tag_t             r_tag [TAG_DEPTH];
  logic [LAST_DEPTH-1:0] r_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAG_DEPTH; i++) r_tag[i] <= TAG_NONE;
      r_last <= '0;
    end else begin
      r_tag[0] <= i_tag;
      for (int i = 1; i < TAG_DEPTH; i++) r_tag[i] <= r_tag[i-1];
      r_last <= {r_last[LAST_DEPTH-2:0], i_last};
    end
  end

  assign o_tag  = r_tag[TAG_DEPTH-1];
  assign o_last = r_last[LAST_DEPTH-1];

endmodule

// File: rtl/dsp_slice_mac_sequencer.sv
// Purpose : drives one int8 dsp_slice through a dot product and returns the sum.
// Latency : last operand accepted in cycle t -> res_valid in t+4; cmd_len=0 -> next cycle.
// Backpressure: one command in flight; cmd_ready held low until the result is consumed.
// Ports   : cmd_* (valid/ready command with pair count), op_* (valid/ready operand
//           pairs), res_* (valid/ready result), slice_* (to/from the dsp_slice), busy.
module dsp_slice_mac_sequencer
  import dsp_seq_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [DWIDTH-1:0] op_a,
  input  logic [DWIDTH-1:0] op_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DWIDTH-1:0] res_data,
  output logic [DWIDTH-1:0] slice_ax,
  output logic [DWIDTH-1:0] slice_ay,
  output logic [DWIDTH-1:0] slice_az,
  output logic              slice_carry_in,
  output logic              slice_multiply,
  output logic              slice_accumulate,
  input  logic [DWIDTH-1:0] slice_result,
  output logic              busy
);

  seq_state_t        r_state;
  logic              r_alive;      // low until the first clock after reset release
  logic [LEN_W-1:0]  r_remaining;
  logic              r_first;
  logic [DWIDTH-1:0] r_res_data;
  logic [DWIDTH-1:0] r_ay;
  logic [DWIDTH-1:0] r_az;

  logic      w_cmd_acc;
  logic      w_op_acc;
  logic      w_last;
  slot_tag_t w_tag;
  slot_tag_t w_ctrl_tag;
  logic      w_cap_last;

  assign cmd_ready = r_alive && (r_state == ST_IDLE);
  assign op_ready  = (r_state == ST_STREAM);
  assign res_valid = (r_state == ST_HOLD);
  assign busy      = (r_state != ST_IDLE);
  assign res_data  = r_res_data;

  assign w_cmd_acc = cmd_valid && cmd_ready;
  assign w_op_acc  = op_valid && op_ready;
  assign w_last    = w_op_acc && (r_remaining == LEN_W'(1));

  // Every STREAM slot that is not the first pair is ACC, bubbles included:
  // a bubble issues zero operands, so adding its product leaves the sum intact.
  always_comb begin
    w_tag = TAG_NONE;
    if (r_state == ST_STREAM) begin
      w_tag = (w_op_acc && r_first) ? TAG_MUL : TAG_ACC;
    end
  end

  dsp_seq_ctrl_pipe #(
    .TAG_DEPTH  (CTRL_DELAY),
    .LAST_DEPTH (CAPTURE_DELAY)
  ) u_ctrl_pipe (
    .clk    (clk),
    .rst_n  (reset),
    .i_tag  (w_tag),
    .i_last (w_last),
    .o_tag  (w_ctrl_tag),
    .o_last (w_cap_last)
  );

  assign slice_ax         = '0;
  assign slice_carry_in   = 1'b0;
  assign slice_ay         = r_ay;
  assign slice_az         = r_az;
  assign slice_multiply   = (w_ctrl_tag == TAG_MUL);
  assign slice_accumulate = (w_ctrl_tag == TAG_ACC);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_alive     <= 1'b0;
      r_remaining <= '0;
      r_first     <= 1'b0;
      r_res_data  <= '0;
      r_ay        <= '0;
      r_az        <= '0;
    end else begin
      r_alive <= 1'b1;
      r_ay    <= w_op_acc ? op_a : '0;
      r_az    <= w_op_acc ? op_b : '0;
      case (r_state)
        ST_IDLE: begin
          if (w_cmd_acc) begin
            if (cmd_len == '0) begin
              r_res_data <= '0;
              r_state    <= ST_HOLD;
            end else begin
              r_remaining <= cmd_len;
              r_first     <= 1'b1;
              r_state     <= ST_STREAM;
            end
          end
        end
        ST_STREAM: begin
          if (w_op_acc) begin
            r_remaining <= r_remaining - LEN_W'(1);
            r_first     <= 1'b0;
            if (w_last) r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Last slot's sum is on slice_result exactly when its flag emerges.
          if (w_cap_last) begin
            r_res_data <= slice_result;
            r_state    <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (res_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dsp_slice_mac_sequencer.sv
// Purpose : directed self-checking bench for dsp_slice_mac_sequencer with a dsp_slice model.
// Latency : n/a (testbench).
// Backpressure: res_ready driven by the directed steps.
module tb_dsp_slice_mac_sequencer;
  localparam int DW = 8;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [LW-1:0] cmd_len = '0;
  logic          op_valid = 1'b0;
  logic          op_ready;
  logic [DW-1:0] op_a = '0;
  logic [DW-1:0] op_b = '0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [DW-1:0] res_data;
  logic [DW-1:0] slice_ax, slice_ay, slice_az;
  logic          slice_carry_in, slice_multiply, slice_accumulate;
  logic [DW-1:0] slice_result;
  logic          busy;

  int n_vec = 0;
  int n_err = 0;
  int n_mul = 0;

  always #5 clk = ~clk;

  dsp_slice_mac_sequencer #(.DWIDTH(DW), .LEN_W(LW)) dut (
    .clk              (clk),
    .reset            (reset),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_len          (cmd_len),
    .op_valid         (op_valid),
    .op_ready         (op_ready),
    .op_a             (op_a),
    .op_b             (op_b),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .res_data         (res_data),
    .slice_ax         (slice_ax),
    .slice_ay         (slice_ay),
    .slice_az         (slice_az),
    .slice_carry_in   (slice_carry_in),
    .slice_multiply   (slice_multiply),
    .slice_accumulate (slice_accumulate),
    .slice_result     (slice_result),
    .busy             (busy)
  );

  // dsp_slice model: product register, then mode-selected result register.
  // Products saturate to int8, accumulation wraps. Not reset (stale state is harmless).
  logic [DW-1:0] m_mult = '0;
  logic [DW-1:0] m_res  = '0;

  function automatic logic [DW-1:0] sat_mul(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int p;
    p = int'(signed'(a)) * int'(signed'(b));
    if (p > 127) return 8'h7F;
    if (p < -128) return 8'h80;
    return p[DW-1:0];
  endfunction

  always @(posedge clk) begin
    m_mult <= sat_mul(slice_ay, slice_az);
    if (slice_multiply) m_res <= m_mult;
    else if (slice_accumulate) m_res <= m_res + m_mult;
  end
  assign slice_result = m_res;

  always @(negedge clk) if (slice_multiply) n_mul++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [LW-1:0] len);
    logic acc;
    acc = 1'b0;
    cmd_valid = 1'b1;
    cmd_len   = len;
    for (int k = 0; k < 20 && !acc; k++) begin
      acc = cmd_ready;
      tick();
    end
    cmd_valid = 1'b0;
    if (!acc) check("cmd_accept_timeout", {31'd0, acc}, 32'd1);
  endtask

  task automatic send_pair(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic acc;
    acc = 1'b0;
    op_valid = 1'b1;
    op_a = a;
    op_b = b;
    for (int k = 0; k < 20 && !acc; k++) begin
      acc = op_ready;
      tick();
    end
    op_valid = 1'b0;
    op_a = '0;
    op_b = '0;
    if (!acc) check("op_accept_timeout", {31'd0, acc}, 32'd1);
  endtask

  // Called right after the last accept (we are in cycle t+1); returns n with
  // res_valid first seen in cycle t+n.
  task automatic wait_res(output int lat);
    lat = 1;
    while (!res_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic consume();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int mul0;

    // Reset state while asserted
    #1;
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_op_ready", {31'd0, op_ready}, 32'd0);
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_res_data", {24'd0, res_data}, 32'h00);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_mode", {30'd0, slice_multiply, slice_accumulate}, 32'd0);
    check("rst_ay_az", {16'd0, slice_ay, slice_az}, 32'd0);
    check("const_ax_cin", {23'd0, slice_ax, slice_carry_in}, 32'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // 2*3 + 4*5 + (-1)*6 = 20, back-to-back
    send_cmd(8'd3);
    check("t1_busy", {31'd0, busy}, 32'd1);
    check("t1_op_ready", {31'd0, op_ready}, 32'd1);
    send_pair(8'd2, 8'd3);
    send_pair(8'd4, 8'd5);
    send_pair(8'hFF, 8'd6);
    check("t1_op_ready_drop", {31'd0, op_ready}, 32'd0);
    wait_res(lat);
    check("t1_latency", lat, 32'd4);
    check("t1_res_data", {24'd0, res_data}, 32'h14);
    check("t1_cmd_ready_hold", {31'd0, cmd_ready}, 32'd0);
    consume();
    check("t1_res_valid_clr", {31'd0, res_valid}, 32'd0);
    check("t1_cmd_ready_back", {31'd0, cmd_ready}, 32'd1);

    // 100*100 saturates to 0x7F
    send_cmd(8'd1);
    send_pair(8'd100, 8'd100);
    wait_res(lat);
    check("t2_latency", lat, 32'd4);
    check("t2_res_data", {24'd0, res_data}, 32'h7F);
    consume();

    // 127 + 1 wraps to 0x80
    send_cmd(8'd2);
    send_pair(8'd127, 8'd1);
    send_pair(8'd1, 8'd1);
    wait_res(lat);
    check("t3_res_data", {24'd0, res_data}, 32'h80);
    consume();

    // 3*3 + 2*(-2) = 5 with a 3-cycle bubble; one multiply pulse only
    mul0 = n_mul;
    send_cmd(8'd2);
    send_pair(8'd3, 8'd3);
    tick();
    tick();
    tick();
    send_pair(8'd2, 8'hFE);
    wait_res(lat);
    check("t4_latency", lat, 32'd4);
    check("t4_res_data", {24'd0, res_data}, 32'h05);
    check("t4_mul_pulses", n_mul - mul0, 32'd1);
    consume();

    // cmd_len = 0 with res_ready held low
    send_cmd(8'd0);
    check("t5_res_valid", {31'd0, res_valid}, 32'd1);
    check("t5_res_data", {24'd0, res_data}, 32'h00);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t5_hold_valid", {31'd0, res_valid}, 32'd1);
      check("t5_hold_data", {24'd0, res_data}, 32'h00);
      check("t5_hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    end
    consume();
    check("t5_res_valid_clr", {31'd0, res_valid}, 32'd0);
    check("t5_cmd_ready_back", {31'd0, cmd_ready}, 32'd1);

    // Reset mid-command after 2 of 4 pairs
    send_cmd(8'd4);
    send_pair(8'd1, 8'd1);
    send_pair(8'd2, 8'd2);
    op_valid = 1'b1;
    op_a = 8'd3;
    op_b = 8'd3;
    #2;
    reset = 1'b0;
    #1;
    check("t6_rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("t6_rst_op_ready", {31'd0, op_ready}, 32'd0);
    check("t6_rst_mode", {30'd0, slice_multiply, slice_accumulate}, 32'd0);
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    check("t6_rst_ay", {24'd0, slice_ay}, 32'd0);
    op_valid = 1'b0;
    op_a = '0;
    op_b = '0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    send_cmd(8'd1);
    send_pair(8'd7, 8'd7);
    wait_res(lat);
    check("t6_latency", lat, 32'd4);
    check("t6_res_data", {24'd0, res_data}, 32'h31);
    consume();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
